// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg -- shared definitions for the two-digit scrolling display controller.
//
// Contents:
//   seg_state_e  : controller FSM state encoding (BLANK / STATIC / SCROLL)
//   SCROLL_LEN   : number of scroll positions (a 2-digit window over 8 nibbles)
//   LAST_POS     : final position index, SCROLL_LEN-1
//   nibble()     : extract nibble <idx> from a 32-bit word (nibble 7 = [31:28])
// ---------------------------------------------------------------------------
package seg_pkg;

  typedef enum logic [1:0] {
    ST_BLANK  = 2'd0,
    ST_STATIC = 2'd1,
    ST_SCROLL = 2'd2
  } seg_state_e;

  // A two-digit window sliding across eight nibbles stops at seven positions.
  localparam int unsigned SCROLL_LEN = 7;
  localparam logic [2:0]  LAST_POS   = 3'(SCROLL_LEN - 1);

  function automatic logic [3:0] nibble(input logic [31:0] word,
                                        input logic [2:0]  idx);
    return word[{idx, 2'b00} +: 4];
  endfunction

endpackage : seg_pkg

// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen -- scroll-step prescaler.
//
// Counts 0..TICK_DIV-1 while clear is low and emits a single-cycle tick
// during the last count, then restarts from 0. While clear is high the
// counter is held at 0 and no tick is produced.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous reset, active low
//   clear  : hold counter at zero, suppress tick
//   tick   : 1-cycle pulse on the final count of each TICK_DIV period
// ---------------------------------------------------------------------------
module tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  // Widened to 64 bits so TICK_DIV = 2^32-1 does not overflow the +1.
  localparam int CW = $clog2(64'(TICK_DIV) + 64'd1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Combinational so the step lands exactly TICK_DIV cycles after the clear
  // is released; with TICK_DIV = 1 this is high on every enabled cycle.
  assign tick = !clear && (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : tick_gen

// File: rtl/seg_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scroll_ctrl -- two-digit 7-segment display controller with static and
// one-shot scroll modes. Drives nibble codes to an external segment decoder.
//
// Handshake: wr_ready is a combinational function of state only (high in
// BLANK and STATIC, low in SCROLL). A write is accepted on a rising edge
// where wr_en=1, wr_ready=1 and clr=0; otherwise wr_en has no effect.
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous reset, active low, overrides everything
//   wr_en      : write strobe
//   wr_data    : eight hex nibbles, nibble 7 = [31:28]
//   wr_mode    : 0 = static (show nibbles 1,0), 1 = one-shot scroll
//   clr        : blank display and abort scroll; beats a simultaneous write
//   wr_ready   : write can be accepted this cycle
//   busy       : scroll in progress (registered)
//   seg_data_1 : left digit nibble (registered)
//   seg_data_2 : right digit nibble (registered)
//   seg_en     : digit enables, bit1 = left, bit0 = right (registered)
//   dbg_state  : current FSM state, for observation only
// ---------------------------------------------------------------------------
module seg_scroll_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        wr_mode,
  input  logic        clr,
  output logic        wr_ready,
  output logic        busy,
  output logic [3:0]  seg_data_1,
  output logic [3:0]  seg_data_2,
  output logic [1:0]  seg_en,
  output seg_state_e  dbg_state
);

  seg_state_e  state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [2:0]  pos_q, pos_d;
  logic        busy_q, busy_d;
  logic [3:0]  seg1_q, seg1_d;
  logic [3:0]  seg2_q, seg2_d;
  logic [1:0]  seg_en_q, seg_en_d;

  logic        accept;
  logic        tick;
  logic        presc_clear;
  logic [2:0]  next_hi_idx;
  logic [2:0]  next_lo_idx;

  assign wr_ready = (state_q != ST_SCROLL);
  assign accept   = wr_en && wr_ready && !clr;

  // Prescaler only runs while scrolling; held at zero otherwise so every
  // scroll starts from a clean count.
  assign presc_clear = clr || (state_q != ST_SCROLL);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (presc_clear),
    .tick  (tick)
  );

  // Nibbles shown at position p+1: left = 7-(p+1), right = 6-(p+1).
  assign next_hi_idx = 3'd6 - pos_q;
  assign next_lo_idx = 3'd5 - pos_q;

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    pos_d    = pos_q;
    busy_d   = busy_q;
    seg1_d   = seg1_q;
    seg2_d   = seg2_q;
    seg_en_d = seg_en_q;

    if (clr) begin
      // Digit codes are left alone; only the enables blank.
      state_d  = ST_BLANK;
      pos_d    = '0;
      busy_d   = 1'b0;
      seg_en_d = 2'b00;
    end else begin
      unique case (state_q)
        ST_BLANK, ST_STATIC: begin
          if (accept) begin
            word_d   = wr_data;
            seg_en_d = 2'b11;
            pos_d    = '0;
            if (wr_mode) begin
              state_d = ST_SCROLL;
              busy_d  = 1'b1;
              seg1_d  = nibble(wr_data, 3'd7);
              seg2_d  = nibble(wr_data, 3'd6);
            end else begin
              state_d = ST_STATIC;
              busy_d  = 1'b0;
              seg1_d  = nibble(wr_data, 3'd1);
              seg2_d  = nibble(wr_data, 3'd0);
            end
          end
        end
        ST_SCROLL: begin
          if (tick) begin
            if (pos_q == LAST_POS) begin
              state_d = ST_STATIC;
              busy_d  = 1'b0;
              pos_d   = '0;
              seg1_d  = nibble(word_q, 3'd1);
              seg2_d  = nibble(word_q, 3'd0);
            end else begin
              pos_d  = pos_q + 3'd1;
              seg1_d = nibble(word_q, next_hi_idx);
              seg2_d = nibble(word_q, next_lo_idx);
            end
          end
        end
        default: begin
          state_d  = ST_BLANK;
          pos_d    = '0;
          busy_d   = 1'b0;
          seg_en_d = 2'b00;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_BLANK;
      word_q   <= '0;
      pos_q    <= '0;
      busy_q   <= 1'b0;
      seg1_q   <= '0;
      seg2_q   <= '0;
      seg_en_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      pos_q    <= pos_d;
      busy_q   <= busy_d;
      seg1_q   <= seg1_d;
      seg2_q   <= seg2_d;
      seg_en_q <= seg_en_d;
    end
  end

  assign busy       = busy_q;
  assign seg_data_1 = seg1_q;
  assign seg_data_2 = seg2_q;
  assign seg_en     = seg_en_q;
  assign dbg_state  = state_q;

endmodule : seg_scroll_ctrl

// File: doc/seg_scroll_ctrl.md
SEG_SCROLL_CTRL -- requirements
Module: seg_scroll_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000, clk cycles per scroll step (1 s at 50 MHz); legal range 1..2^32-1.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous reset, active low.
REQ-004 SHALL have port wr_en  input  1  write strobe, sampled each cycle.
REQ-005 SHALL have port wr_data  input  32  eight hex nibbles; nibble 7 = bits 31:28.
REQ-006 SHALL have port wr_mode  input  1  0 = static, 1 = one-shot scroll.
REQ-007 SHALL have port clr  input  1  blank display and abort any scroll.
REQ-008 SHALL have port wr_ready  output  1  write accepted this cycle when wr_en=1.
REQ-009 SHALL have port busy  output  1  scroll in progress.
REQ-010 SHALL have port seg_data_1  output  4  nibble code for left digit, to the 7-segment decoder.
REQ-011 SHALL have port seg_data_2  output  4  nibble code for right digit, to the 7-segment decoder.
REQ-012 SHALL have port seg_en  output  2  digit enables; bit1 = left, bit0 = right; 0 = blank.

Function
REQ-013 SHALL implement FSM states BLANK, STATIC, SCROLL.
REQ-014 SHALL drive wr_ready = 1 in BLANK and STATIC and 0 in SCROLL, combinationally from state.
REQ-015 SHALL define an accepted write as wr_en=1 and wr_ready=1 and clr=0 on a rising edge.
REQ-016 SHALL latch wr_data into a 32-bit word register on an accepted write; outputs reflect it from the next cycle (latency 1).
REQ-017 Accepted write with wr_mode=0 SHALL enter STATIC with seg_data_1=word[7:4], seg_data_2=word[3:0], seg_en=2'b11.
REQ-018 Accepted write with wr_mode=1 SHALL enter SCROLL with position p=0, clear the prescaler and assert busy.
REQ-019 In SCROLL, SHALL show seg_data_1=nibble(7-p), seg_data_2=nibble(6-p), seg_en=2'b11, for p=0..6.
REQ-020 Each position SHALL be held exactly TICK_DIV cycles; the prescaler counts 0..TICK_DIV-1 and then p increments.
REQ-021 After p=6 has been held TICK_DIV cycles, SHALL enter STATIC showing nibbles 1,0 and deassert busy; total scroll is 7*TICK_DIV cycles.
REQ-022 wr_en during SCROLL SHALL be ignored, with no effect on the word register, p or prescaler.
REQ-023 Accepted write in STATIC SHALL replace the word and re-enter per REQ-017/REQ-018.
REQ-024 clr=1 SHALL, on the next edge, enter BLANK with seg_en=2'b00, busy=0, p=0 and prescaler=0, from any state; it has priority over a simultaneous wr_en.
REQ-025 In BLANK, seg_data_1/seg_data_2 SHALL hold their last values; only seg_en blanks.
REQ-026 With TICK_DIV=1, p SHALL advance every cycle, giving a scroll of 7 cycles.
REQ-027 The prescaler SHALL be ceil(log2(TICK_DIV+1)) bits wide with no wrap beyond TICK_DIV-1; p SHALL be 3 bits and never exceed 6.
REQ-028 All outputs except wr_ready SHALL be registered.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force state BLANK, word=0, p=0, prescaler=0, busy=0, seg_data_1=0, seg_data_2=0 and seg_en=2'b00; wr_ready=1 follows from BLANK.
REQ-030 Reset SHALL override clr and wr_en, and SHALL abort a scroll mid-operation with no residual state.

Structure
REQ-031 State encoding and the scroll-length constant (7 positions) SHALL live in a shared package, seg_pkg.
REQ-032 The prescaler SHALL be a sub-module tick_gen (parameter TICK_DIV; inputs clk, rst_n, clear; output tick, a 1-cycle pulse).
REQ-033 The block SHALL NOT contain the segment decode table; seg_data_1/2 feed the existing decoder unchanged.

Verification (TICK_DIV=4)
REQ-034 Reset, then idle: seg_en=00, busy=0, wr_ready=1, seg_data_1/2=0.
REQ-035 Write 0x000000A5, mode 0: next cycle seg_data_1=A, seg_data_2=5, seg_en=11, busy=0.
REQ-036 Write 0x12345678, mode 1: pairs (1,2),(2,3),...,(7,8), each held 4 cycles; busy high 28 cycles; then STATIC showing (7,8).
REQ-037 During that scroll, write 0xFFFFFFFF at cycle 10: ignored, sequence unchanged, wr_ready=0 throughout the scroll.
REQ-038 clr at cycle 9 of a scroll, with simultaneous wr_en: next cycle BLANK, seg_en=00, busy=0, write not taken.
REQ-039 rst_n low at cycle 5 of a scroll: next cycle full reset values; a subsequent mode-0 write of 0x3C shows (3,C).
